// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Operand forwarding and hazard detection for the decode stage of an in-order
// pipeline. For each read port it picks the youngest pipeline stage that will
// write the requested register. If there is no such stage, it uses a
// long-latency writeback in the same cycle. If there is neither, it checks a
// scoreboard of long-latency destinations that are still outstanding. It also
// detects write-after-write hazards against that scoreboard.
//
// Ports
//   clk, rst          single clock; synchronous active-high reset
//   issue_valid       decode presents an instruction
//   issue_rd          destination register of the issuing instruction
//   issue_reg_write   issuing instruction writes issue_rd
//   issue_long        issuing instruction completes only through wb_*
//   rs                source register per read port
//   fwd_valid/rd/ready/data
//                     per forwarding stage (0 = youngest); ready=0 marks a
//                     result that is not yet available (load in MEM)
//   wb_valid/rd/data  long-latency completion, usable as a same-cycle bypass
//   data, data_valid  forwarded operand per port; data_valid overrides the
//                     register-file value
//   stall             decode must hold; the issue is not accepted
//   busy_mask         registered scoreboard of pending long-latency writes
//   stall_cycles      saturating count of cycles with stall asserted
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int XLEN           = 32,
    parameter int NUM_READ_PORTS = 2,
    parameter int NUM_FWD_STAGES = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,

    input  logic                                     issue_valid,
    input  logic [4:0]                               issue_rd,
    input  logic                                     issue_reg_write,
    input  logic                                     issue_long,

    input  logic [NUM_READ_PORTS-1:0][4:0]           rs,

    input  logic [NUM_FWD_STAGES-1:0]                fwd_valid,
    input  logic [NUM_FWD_STAGES-1:0][4:0]           fwd_rd,
    input  logic [NUM_FWD_STAGES-1:0]                fwd_ready,
    input  logic [NUM_FWD_STAGES-1:0][XLEN-1:0]      fwd_data,

    input  logic                                     wb_valid,
    input  logic [4:0]                               wb_rd,
    input  logic [XLEN-1:0]                          wb_data,

    output logic [NUM_READ_PORTS-1:0][XLEN-1:0]      data,
    output logic [NUM_READ_PORTS-1:0]                data_valid,
    output logic                                     stall,
    output logic [31:0]                              busy_mask,
    output logic [31:0]                              stall_cycles
);

    localparam logic [NUM_FWD_STAGES-1:0] STAGE_ONE = NUM_FWD_STAGES'(1);
    localparam logic [31:0]               CNT_MAX   = 32'hFFFF_FFFF;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0] busy_mask_q,    busy_mask_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // While reset is asserted, every pending long op is treated as forgotten.
    // The scoreboard that decode sees therefore already matches the cleared
    // state it will hold after the reset edge.
    logic [31:0] sb_view;

    assign sb_view = rst ? 32'h0 : busy_mask_q;

    // -------------------------------------------------------------------------
    // Per-port match detection
    // -------------------------------------------------------------------------
    logic [NUM_READ_PORTS-1:0][NUM_FWD_STAGES-1:0] stage_hit;
    logic [NUM_READ_PORTS-1:0][NUM_FWD_STAGES-1:0] stage_sel;
    logic [NUM_READ_PORTS-1:0]                     any_stage_hit;
    logic [NUM_READ_PORTS-1:0]                     wb_hit;
    logic [NUM_READ_PORTS-1:0]                     sb_hit;
    logic [NUM_READ_PORTS-1:0]                     port_stall;

    // x0 is hard-wired zero, so a read of x0 never matches anything.
    always_comb begin
        stage_hit = '0;
        wb_hit    = '0;
        sb_hit    = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (rs[p] != 5'd0) begin
                for (int k = 0; k < NUM_FWD_STAGES; k++) begin
                    stage_hit[p][k] = fwd_valid[k] && (fwd_rd[k] == rs[p]);
                end
                wb_hit[p] = wb_valid && (wb_rd == rs[p]);
                sb_hit[p] = sb_view[rs[p]];
            end
        end
    end

    // The youngest matching stage wins. Isolating the lowest set bit yields a
    // one-hot select. Once a stage is selected, an older stage is never used
    // for that port, even when the selected stage is not ready yet.
    always_comb begin
        stage_sel     = '0;
        any_stage_hit = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            stage_sel[p]     = stage_hit[p] & (~stage_hit[p] + STAGE_ONE);
            any_stage_hit[p] = |stage_hit[p];
        end
    end

    // -------------------------------------------------------------------------
    // Operand selection and per-port stall
    // -------------------------------------------------------------------------
    always_comb begin
        data       = '0;
        data_valid = '0;
        port_stall = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (any_stage_hit[p]) begin
                for (int k = 0; k < NUM_FWD_STAGES; k++) begin
                    if (stage_sel[p][k]) begin
                        if (fwd_ready[k]) begin
                            data[p]       = fwd_data[k];
                            data_valid[p] = 1'b1;
                        end else begin
                            port_stall[p] = 1'b1;
                        end
                    end
                end
            end else if (wb_hit[p]) begin
                data[p]       = wb_data;
                data_valid[p] = 1'b1;
            end else if (sb_hit[p]) begin
                port_stall[p] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // WAW hazard, global stall, issue acceptance
    // -------------------------------------------------------------------------
    logic waw_hit;
    logic wb_clears_issue_rd;
    logic issue_fire;
    logic sb_set;
    logic sb_clr;

    // A writeback to the same register in this cycle retires the older long
    // op. The new writer can then issue without waiting another cycle.
    assign wb_clears_issue_rd = wb_valid && (wb_rd == issue_rd);
    assign waw_hit            = issue_reg_write && (issue_rd != 5'd0) &&
                                sb_view[issue_rd] && !wb_clears_issue_rd;

    assign stall      = issue_valid && ((|port_stall) || waw_hit);
    assign issue_fire = issue_valid && !stall;

    assign sb_set = issue_fire && issue_long && issue_reg_write &&
                    (issue_rd != 5'd0);
    assign sb_clr = wb_valid && (wb_rd != 5'd0);

    // -------------------------------------------------------------------------
    // Scoreboard next state
    // -------------------------------------------------------------------------
    // The clear is applied before the set. When the same register is both
    // retired and re-issued in one cycle, the new issue therefore keeps the
    // bit set. A writeback to a register that is not busy clears a bit that
    // is already zero, so it has no effect.
    always_comb begin
        busy_mask_d = busy_mask_q;
        if (sb_clr) begin
            busy_mask_d[wb_rd] = 1'b0;
        end
        if (sb_set) begin
            busy_mask_d[issue_rd] = 1'b1;
        end
        busy_mask_d[0] = 1'b0;
    end

    // -------------------------------------------------------------------------
    // Stall cycle counter (saturating)
    // -------------------------------------------------------------------------
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask_q    <= 32'h0;
            stall_cycles_q <= 32'h0;
        end else begin
            busy_mask_q    <= busy_mask_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign busy_mask    = busy_mask_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    localparam int XL = 32;
    localparam int NR = 2;
    localparam int NF = 2;

    logic                     clk;
    logic                     rst;
    logic                     issue_valid;
    logic [4:0]               issue_rd;
    logic                     issue_reg_write;
    logic                     issue_long;
    logic [NR-1:0][4:0]       rs;
    logic [NF-1:0]            fwd_valid;
    logic [NF-1:0][4:0]       fwd_rd;
    logic [NF-1:0]            fwd_ready;
    logic [NF-1:0][XL-1:0]    fwd_data;
    logic                     wb_valid;
    logic [4:0]               wb_rd;
    logic [XL-1:0]            wb_data;
    logic [NR-1:0][XL-1:0]    data;
    logic [NR-1:0]            data_valid;
    logic                     stall;
    logic [31:0]              busy_mask;
    logic [31:0]              stall_cycles;

    hazard_forward_unit #(
        .XLEN(XL), .NUM_READ_PORTS(NR), .NUM_FWD_STAGES(NF)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_reg_write(issue_reg_write), .issue_long(issue_long),
        .rs(rs),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_ready(fwd_ready),
        .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .data(data), .data_valid(data_valid), .stall(stall),
        .busy_mask(busy_mask), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: a set of pending long-op registers and a plain
    // integer count of stalled cycles.
    bit          pending [32];
    longint      m_cnt;
    bit          regs_known;

    int checks;
    int failures;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_pending(input logic [4:0] r);
        if (rst) return 1'b0;
        return pending[r];
    endfunction

    // Resolve one read port from the rules: youngest stage, then wb, then scoreboard.
    function automatic void model_port(input int p, output logic [XL-1:0] d,
                                       output logic v, output logic s);
        int hit;
        d = '0; v = 1'b0; s = 1'b0; hit = -1;
        if (rs[p] == 5'd0) return;
        for (int k = 0; k < NF; k++)
            if (hit < 0 && fwd_valid[k] && fwd_rd[k] == rs[p]) hit = k;
        if (hit >= 0) begin
            if (fwd_ready[hit]) begin d = fwd_data[hit]; v = 1'b1; end
            else s = 1'b1;
        end else if (wb_valid && wb_rd == rs[p]) begin
            d = wb_data; v = 1'b1;
        end else if (is_pending(rs[p])) begin
            s = 1'b1;
        end
    endfunction

    function automatic bit model_stall();
        logic [XL-1:0] d; logic v; logic s;
        bit any;
        any = 1'b0;
        for (int p = 0; p < NR; p++) begin
            model_port(p, d, v, s);
            if (s) any = 1'b1;
        end
        if (issue_reg_write && issue_rd != 5'd0 && is_pending(issue_rd) &&
            !(wb_valid && wb_rd == issue_rd)) any = 1'b1;
        return issue_valid && any;
    endfunction

    function automatic logic [31:0] pending_word();
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = pending[i];
        return w;
    endfunction

    task automatic compare_model();
        logic [XL-1:0] d; logic v; logic s;
        for (int p = 0; p < NR; p++) begin
            model_port(p, d, v, s);
            chk($sformatf("model data[%0d]", p), 64'(data[p]), 64'(d));
            chk($sformatf("model data_valid[%0d]", p), 64'(data_valid[p]), 64'(v));
        end
        chk("model stall", 64'(stall), 64'(model_stall()));
        if (regs_known) begin
            chk("model busy_mask", 64'(busy_mask), 64'(pending_word()));
            chk("model stall_cycles", 64'(stall_cycles), 64'(m_cnt));
        end
    endtask

    task automatic model_update();
        bit st;
        st = model_stall();
        if (rst) begin
            for (int i = 0; i < 32; i++) pending[i] = 1'b0;
            m_cnt = 0;
            regs_known = 1'b1;
        end else begin
            if (st && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt = m_cnt + 1;
            if (wb_valid && wb_rd != 5'd0) pending[wb_rd] = 1'b0;
            if (issue_valid && !st && issue_long && issue_reg_write && issue_rd != 5'd0)
                pending[issue_rd] = 1'b1;
        end
    endtask

    // eval: sample at the falling edge and compare against the model.
    // adv: take the rising edge, advance the model, then move off the edge.
    task automatic eval();
        @(negedge clk);
        compare_model();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_in();
        issue_valid = 0; issue_rd = 0; issue_reg_write = 0; issue_long = 0;
        rs = '0; fwd_valid = '0; fwd_rd = '0; fwd_ready = '0; fwd_data = '0;
        wb_valid = 0; wb_rd = 0; wb_data = '0;
    endtask

    task automatic issue_long_rd(input logic [4:0] r);
        issue_valid = 1; issue_long = 1; issue_reg_write = 1; issue_rd = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0; m_cnt = 0; regs_known = 1'b0;
        for (int i = 0; i < 32; i++) pending[i] = 1'b0;
        clear_in();
        rst = 1;
        eval(); adv();
        eval(); adv();
        rst = 0;
        eval();
        chk("reset busy_mask", 64'(busy_mask), 64'h0);
        chk("reset stall_cycles", 64'(stall_cycles), 64'h0);
        adv();

        // Youngest stage wins over the older one.
        clear_in(); issue_valid = 1;
        rs[0] = 5; fwd_valid = 2'b11; fwd_rd[0] = 5; fwd_rd[1] = 5; fwd_ready = 2'b11;
        fwd_data[0] = 32'h11; fwd_data[1] = 32'h22;
        eval();
        chk("youngest data[0]", 64'(data[0]), 64'h11);
        chk("youngest data_valid[0]", 64'(data_valid[0]), 64'h1);
        chk("youngest stall", 64'(stall), 64'h0);
        adv();

        // Only the older stage is valid; the invalid stage0 must be ignored.
        clear_in(); issue_valid = 1;
        rs[1] = 6; fwd_valid = 2'b10; fwd_rd[0] = 6; fwd_rd[1] = 6; fwd_ready = 2'b11;
        fwd_data[0] = 32'h99; fwd_data[1] = 32'h66;
        eval();
        chk("stage1 data[1]", 64'(data[1]), 64'h66);
        chk("stage1 data_valid[1]", 64'(data_valid[1]), 64'h1);
        adv();

        // Load-use: youngest match not ready blocks the older ready match.
        clear_in(); issue_valid = 1;
        rs[1] = 7; fwd_valid = 2'b11; fwd_rd[0] = 7; fwd_rd[1] = 7; fwd_ready = 2'b10;
        fwd_data[0] = 32'h70; fwd_data[1] = 32'h71;
        eval();
        chk("load-use stall", 64'(stall), 64'h1);
        chk("load-use data_valid[1]", 64'(data_valid[1]), 64'h0);
        adv();
        issue_valid = 0;
        eval();
        chk("stall gated by issue_valid", 64'(stall), 64'h0);
        chk("stall_cycles after one stall", 64'(stall_cycles), 64'h1);
        adv();

        // Long op rd=9, then RAW on the scoreboard, then same-cycle wb bypass.
        clear_in(); issue_long_rd(9);
        eval(); adv();
        clear_in(); issue_valid = 1; rs[0] = 9;
        eval();
        chk("busy_mask[9] set", 64'(busy_mask[9]), 64'h1);
        chk("scoreboard RAW stall", 64'(stall), 64'h1);
        adv();
        wb_valid = 1; wb_rd = 9; wb_data = 32'hABCD;
        eval();
        chk("wb bypass stall", 64'(stall), 64'h0);
        chk("wb bypass data[0]", 64'(data[0]), 64'hABCD);
        adv();
        clear_in();
        eval();
        chk("busy_mask[9] cleared", 64'(busy_mask[9]), 64'h0);
        chk("stall_cycles after two stalls", 64'(stall_cycles), 64'h2);
        adv();

        // Same-cycle clear and set of rd=3: the new issue keeps the bit.
        clear_in(); issue_long_rd(3);
        eval(); adv();
        clear_in(); issue_long_rd(3); wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
        eval();
        chk("retire+reissue stall", 64'(stall), 64'h0);
        adv();
        clear_in();
        eval();
        chk("busy_mask[3] after set+clear", 64'(busy_mask[3]), 64'h1);
        adv();
        clear_in(); issue_long_rd(4);
        eval(); adv();
        clear_in(); issue_long_rd(4);
        eval();
        chk("WAW stall", 64'(stall), 64'h1);
        adv();

        // x0 never hits and is never marked busy.
        clear_in(); issue_long_rd(0); rs[0] = 0;
        fwd_valid = 2'b01; fwd_rd[0] = 0; fwd_ready = 2'b01; fwd_data[0] = 32'h55;
        eval();
        chk("x0 data_valid[0]", 64'(data_valid[0]), 64'h0);
        chk("x0 stall", 64'(stall), 64'h0);
        adv();
        // wb to a register that is not busy is harmless.
        clear_in(); wb_valid = 1; wb_rd = 12; wb_data = 32'h0;
        eval(); adv();
        clear_in();
        eval();
        chk("busy_mask regs 3,4 only", 64'(busy_mask), 64'h18);
        adv();

        // Both ports: port0 blocked by the scoreboard, port1 bypassed from wb.
        clear_in(); issue_valid = 1; rs[0] = 3; rs[1] = 12;
        wb_valid = 1; wb_rd = 12; wb_data = 32'hC0FFEE;
        eval();
        chk("two-port stall", 64'(stall), 64'h1);
        chk("two-port data[1]", 64'(data[1]), 64'hC0FFEE);
        chk("two-port data_valid[0]", 64'(data_valid[0]), 64'h0);
        adv();

        // Saturation: preload the counter close to the top, then keep stalling.
        clear_in(); issue_long_rd(4);
        eval();
        force dut.stall_cycles_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cycles_q;
        m_cnt = 64'h0000_0000_FFFF_FFFD;
        adv();
        for (int i = 0; i < 4; i++) begin
            eval(); adv();
        end
        eval();
        chk("stall_cycles saturated", 64'(stall_cycles), 64'hFFFF_FFFF);
        adv();

        // Reset with a concurrent long issue: everything is cleared.
        clear_in(); rst = 1; issue_long_rd(8);
        eval();
        chk("reset-cycle stall", 64'(stall), 64'h0);
        adv();
        rst = 0; clear_in();
        eval();
        chk("post-reset busy_mask", 64'(busy_mask), 64'h0);
        chk("post-reset stall_cycles", 64'(stall_cycles), 64'h0);
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NUM_READ_PORTS, default 2, number of source operands checked per cycle.
REQ-003 SHALL have parameter NUM_FWD_STAGES, default 2, number of forwarding sources; index 0 = youngest (MEM), highest = oldest.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port issue_valid  in  1  decode stage presents an instruction.
REQ-007 SHALL have port issue_rd  in  5  destination register of the issuing instruction.
REQ-008 SHALL have port issue_reg_write  in  1  issuing instruction writes issue_rd.
REQ-009 SHALL have port issue_long  in  1  issuing instruction is long-latency (load miss path, mul/div); its result returns only via wb_*.
REQ-010 SHALL have port rs  in  NUM_READ_PORTS x 5  source register per read port.
REQ-011 SHALL have port fwd_valid  in  NUM_FWD_STAGES x 1  stage holds a register-writing instruction.
REQ-012 SHALL have port fwd_rd  in  NUM_FWD_STAGES x 5  stage destination register.
REQ-013 SHALL have port fwd_ready  in  NUM_FWD_STAGES x 1  stage result is available (0 for a load still in MEM).
REQ-014 SHALL have port fwd_data  in  NUM_FWD_STAGES x XLEN  stage result.
REQ-015 SHALL have port wb_valid, wb_rd, wb_data  in  1 / 5 / XLEN  long-latency completion.
REQ-016 SHALL have port data  out  NUM_READ_PORTS x XLEN  forwarded operand per port.
REQ-017 SHALL have port data_valid  out  NUM_READ_PORTS x 1  data overrides register-file value.
REQ-018 SHALL have port stall  out  1  decode must hold; issue not accepted.
REQ-019 SHALL have port busy_mask  out  32  registered scoreboard of pending long-latency destinations.
REQ-020 SHALL have port stall_cycles  out  32  saturating count of cycles with stall=1.

Function
REQ-021 Issue accepted (issue_fire) SHALL equal issue_valid & ~stall.
REQ-022 Per port p, register x0 SHALL never hit: rs[p]==0 gives data_valid[p]=0, data[p]=0, no stall contribution.
REQ-023 Per port, matching priority SHALL be: stage 0 .. NUM_FWD_STAGES-1 (lowest index wins), then wb_* bypass, then scoreboard.
REQ-024 Stage match (fwd_valid[k] & fwd_rd[k]==rs[p]) with fwd_ready[k]=1 SHALL give data=fwd_data[k], data_valid=1.
REQ-025 Highest-priority stage match with fwd_ready[k]=0 SHALL give data_valid=0 and raise stall; older matches SHALL NOT be used.
REQ-026 No stage match and wb_valid & wb_rd==rs[p] SHALL give data=wb_data, data_valid=1, no stall (same-cycle bypass).
REQ-027 No match above and busy_mask[rs[p]]=1 SHALL raise stall, data_valid=0.
REQ-028 No match at all SHALL give data_valid=0, data=0.
REQ-029 WAW: issue_valid & issue_reg_write & issue_rd!=0 & busy_mask[issue_rd]=1 & ~(wb_valid & wb_rd==issue_rd) SHALL raise stall.
REQ-030 stall SHALL be the OR of all port stall conditions and REQ-029, gated by issue_valid (issue_valid=0 -> stall=0).
REQ-031 data/data_valid/stall SHALL be combinational from inputs and busy_mask, zero-cycle latency.
REQ-032 On issue_fire & issue_long & issue_reg_write & issue_rd!=0, busy_mask[issue_rd] SHALL be 1 next cycle.
REQ-033 On wb_valid & wb_rd!=0, busy_mask[wb_rd] SHALL be 0 next cycle.
REQ-034 Same cycle set and clear of the same register SHALL leave the bit set (new issue wins).
REQ-035 wb_valid for a register not busy SHALL be ignored without error; busy_mask[0] SHALL stay 0.
REQ-036 stall_cycles SHALL increment each cycle stall=1, saturate at 0xFFFF_FFFF, never wrap.

Reset
REQ-037 On rst=1 at a clock edge, busy_mask SHALL become 0 and stall_cycles 0, regardless of concurrent issue or wb.
REQ-038 During rst=1 combinational outputs SHALL follow REQ-022..031 using the cleared scoreboard from the following cycle; pending long ops are forgotten.

Verification
REQ-039 Port0 rs=5, stage0 rd=5 ready data=0x11, stage1 rd=5 data=0x22 -> data[0]=0x11, data_valid[0]=1, stall=0.
REQ-040 Stage0 rd=7 fwd_ready=0 (load), stage1 rd=7 ready, rs[1]=7, issue_valid=1 -> stall=1, data_valid[1]=0, stall_cycles +1.
REQ-041 Issue long rd=9; next cycle rs[0]=9 -> stall=1; wb_valid rd=9 data=0xABCD same cycle -> stall=0, data[0]=0xABCD; next cycle busy_mask[9]=0.
REQ-042 busy_mask[3]=1, wb rd=3 and issue long rd=3 same cycle -> busy_mask[3]=1 after edge; issue long rd=4 while busy_mask[4]=1 -> stall=1 (WAW).
REQ-043 rs=0 with stage0 rd=0 valid, issue long rd=0 -> data_valid=0, stall=0, busy_mask stays 0.
REQ-044 Force stall for 2^32+3 cycles (or preload) -> stall_cycles=0xFFFF_FFFF; assert rst with issue long rd=8 -> busy_mask=0, stall_cycles=0.
